counter_ctrl: RTL and testbench

Run/pause/load/step controller for the board's loadable 3-bit counter datapath.
- Debounces the four active-low push keys and turns each press into a one-cycle event.
- Divides CLOCK_50 down to a count tick and sequences the counter's load, enable and direction.
- Sits between the board top's KEY/SW inputs and the counter; the counter value still feeds the BCD/7-seg display path.

---
 rtl/counter_ctrl_pkg.sv | 16 +
 rtl/key_debounce.sv | 44 ++++
 rtl/counter_ctrl.sv | 131 +++++++++++++
 tb/tb_counter_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared state encodings and key indices for the counter controller.
package counter_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t PAUSE = 2'd2;
  localparam state_t HALT  = 2'd3;

  localparam int unsigned KEY_RUN  = 0;
  localparam int unsigned KEY_LOAD = 1;
  localparam int unsigned KEY_DIR  = 2;
  localparam int unsigned KEY_STEP = 3;

endpackage

// File: rtl/key_debounce.sv
// One active-low push key: 2-flop synchroniser, stability counter, and a
// single-cycle pulse on each accepted press (release produces nothing).
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // Old level high means this accepted change is a press.
        level <= sync2;
        cnt   <= '0;
        press <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/load/step controller for the loadable counter datapath:
// debounced key events, tick prescaler and the IDLE/RUN/PAUSE/HALT FSM.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH        = 3,
  parameter int unsigned TICK_DIV     = 50000000,
  parameter int unsigned DEBOUNCE_CYC = 1000000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [3:0]       key_n,
  input  logic [WIDTH-1:0] sw_load,
  input  logic             stop_mode,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_en,
  output logic             cnt_load,
  output logic             cnt_up,
  output logic [WIDTH-1:0] load_val,
  output logic [1:0]       state_o,
  output logic             tick_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

  logic [3:0] press;

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .clk  (CLOCK_50),
      .rst  (reset),
      .key_n(key_n[g]),
      .press(press[g])
    );
  end

  logic ev_run;
  logic ev_load;
  logic ev_dir;
  logic ev_step;

  assign ev_run  = press[KEY_RUN];
  assign ev_load = press[KEY_LOAD];
  assign ev_dir  = press[KEY_DIR];
  assign ev_step = press[KEY_STEP];

  state_t          state;
  logic [PW-1:0]   presc;
  logic            tick;
  logic            term;
  logic            stop_here;

  state_t          nx_state;
  logic [PW-1:0]   nx_presc;
  logic            nx_en;
  logic            nx_load;
  logic            nx_up;
  logic [WIDTH-1:0] nx_val;

  assign tick      = (state == RUN) && (presc == PLAST);
  assign term      = cnt_up ? (cnt_q == '1) : (cnt_q == '0);
  assign stop_here = stop_mode && term;
  assign state_o   = state;

  always_comb begin
    nx_state = state;
    nx_en    = 1'b0;
    nx_load  = 1'b0;
    nx_val   = load_val;
    nx_up    = cnt_up ^ ev_dir;

    // Load beats run/pause, which beats tick/step; losers are dropped.
    if (ev_load) begin
      nx_load = 1'b1;
      nx_val  = sw_load;
      if (state == HALT) nx_state = PAUSE;
    end else if (ev_run) begin
      case (state)
        IDLE:    nx_state = RUN;
        RUN:     nx_state = PAUSE;
        PAUSE:   nx_state = RUN;
        default: nx_state = state;
      endcase
    end else begin
      case (state)
        RUN: begin
          if (tick) begin
            if (stop_here) nx_state = HALT;
            else           nx_en    = 1'b1;
          end
        end
        PAUSE: begin
          if (ev_step && !stop_here) nx_en = 1'b1;
        end
        default: nx_en = 1'b0;
      endcase
    end

    if ((state == HALT) && ev_dir) nx_state = PAUSE;

    // Prescaler only advances while staying in RUN without a load.
    if ((state == RUN) && (nx_state == RUN) && !ev_load)
      nx_presc = tick ? '0 : presc + 1'b1;
    else
      nx_presc = '0;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      presc    <= '0;
      cnt_en   <= 1'b0;
      cnt_load <= 1'b0;
      cnt_up   <= 1'b1;
      load_val <= '0;
      tick_o   <= 1'b0;
    end else begin
      state    <= nx_state;
      presc    <= nx_presc;
      cnt_en   <= nx_en;
      cnt_load <= nx_load;
      cnt_up   <= nx_up;
      load_val <= nx_val;
      tick_o   <= tick;
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl (TICK_DIV=4, DEBOUNCE_CYC=3, WIDTH=3):
// stimulus queues hand-computed output events, a negedge monitor checks them.
module tb_counter_ctrl;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic [3:0] key_n    = 4'hF;
  logic [2:0] sw_load  = 3'd0;
  logic       stop_mode = 1'b0;
  logic [2:0] cnt_q    = 3'd3;
  logic       cnt_en;
  logic       cnt_load;
  logic       cnt_up;
  logic [2:0] load_val;
  logic [1:0] state_o;
  logic       tick_o;

  counter_ctrl #(
    .WIDTH(3),
    .TICK_DIV(4),
    .DEBOUNCE_CYC(3)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .key_n    (key_n),
    .sw_load  (sw_load),
    .stop_mode(stop_mode),
    .cnt_q    (cnt_q),
    .cnt_en   (cnt_en),
    .cnt_load (cnt_load),
    .cnt_up   (cnt_up),
    .load_val (load_val),
    .state_o  (state_o),
    .tick_o   (tick_o)
  );

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic       up;
    logic       en;
    logic       ld;
    logic       tk;
    logic [2:0] lv;
  } exp_t;

  exp_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [1:0] prev_st = 2'd0;
  logic       prev_up = 1'b1;

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Any pulse or state/direction change is an output event to be matched.
  always @(negedge CLOCK_50) begin
    if (reset) begin
      prev_st = state_o;
      prev_up = cnt_up;
    end else if (cnt_en || cnt_load || state_o != prev_st || cnt_up != prev_up) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: got cyc=%0d st=%0d up=%0b en=%0b ld=%0b lv=%0d tk=%0b, want no event",
                 cyc, state_o, cnt_up, cnt_en, cnt_load, load_val, tick_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.st !== state_o || e.up !== cnt_up || e.en !== cnt_en ||
            e.ld !== cnt_load || e.tk !== tick_o || (e.ld && e.lv !== load_val)) begin
          fails++;
          $display("FAIL event: got cyc=%0d st=%0d up=%0b en=%0b ld=%0b lv=%0d tk=%0b, want cyc=%0d st=%0d up=%0b en=%0b ld=%0b lv=%0d tk=%0b",
                   cyc, state_o, cnt_up, cnt_en, cnt_load, load_val, tick_o,
                   e.cyc, e.st, e.up, e.en, e.ld, e.lv, e.tk);
        end
      end
      prev_st = state_o;
      prev_up = cnt_up;
    end
  end

  function automatic void ex(int c, logic [1:0] st, logic up, logic en, logic ld, logic tk, logic [2:0] lv);
    exp_t e;
    e.cyc = c; e.st = st; e.up = up; e.en = en; e.ld = ld; e.tk = tk; e.lv = lv;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic press_key(input int k, input int hold);
    key_n[k] = 1'b0;
    wait_cyc(hold);
    key_n[k] = 1'b1;
    wait_cyc(6);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    wait_cyc(3);
    check("rst_state", 32'(state_o), 32'(S_IDLE));
    check("rst_en", 32'(cnt_en), 0);
    check("rst_load", 32'(cnt_load), 0);
    check("rst_up", 32'(cnt_up), 1);
    check("rst_val", 32'(load_val), 0);
    check("rst_tick", 32'(tick_o), 0);
    reset = 1'b0;
    wait_cyc(3);

    // Run from IDLE, ticks every 4 cycles, then pause.
    c = cyc;
    ex(c + 6,  S_RUN,   1, 0, 0, 0, 0);
    ex(c + 10, S_RUN,   1, 1, 0, 1, 0);
    ex(c + 14, S_RUN,   1, 1, 0, 1, 0);
    ex(c + 18, S_RUN,   1, 1, 0, 1, 0);
    ex(c + 20, S_PAUSE, 1, 0, 0, 0, 0);
    press_key(0, 8);
    press_key(0, 8);

    // Single step in PAUSE.
    c = cyc;
    ex(c + 6, S_PAUSE, 1, 1, 0, 0, 0);
    press_key(3, 8);

    // Load lands on a RUN tick: load wins, prescaler restarts.
    sw_load = 3'd5;
    c = cyc;
    ex(c + 6,  S_RUN,   1, 0, 0, 0, 0);
    ex(c + 10, S_RUN,   1, 1, 0, 1, 0);
    ex(c + 14, S_RUN,   1, 0, 1, 1, 5);
    ex(c + 18, S_RUN,   1, 1, 0, 1, 0);
    ex(c + 22, S_RUN,   1, 1, 0, 1, 0);
    ex(c + 26, S_RUN,   1, 1, 0, 1, 0);
    ex(c + 28, S_PAUSE, 1, 0, 0, 0, 0);
    key_n[0] = 1'b0;
    wait_cyc(8);
    key_n[0] = 1'b1;
    key_n[1] = 1'b0;
    wait_cyc(8);
    key_n[1] = 1'b1;
    wait_cyc(6);
    press_key(0, 8);

    // Halt at terminal count, then load releases HALT to PAUSE.
    stop_mode = 1'b1;
    cnt_q = 3'd7;
    sw_load = 3'd2;
    c = cyc;
    ex(c + 6,  S_RUN,   1, 0, 0, 0, 0);
    ex(c + 10, S_HALT,  1, 0, 0, 1, 0);
    ex(c + 20, S_PAUSE, 1, 0, 1, 0, 2);
    press_key(0, 8);
    press_key(1, 8);

    // Step at terminal count with stop_mode is ignored.
    press_key(3, 8);

    // HALT again, direction key leaves HALT and reverses; step then counts.
    c = cyc;
    ex(c + 6,  S_RUN,   1, 0, 0, 0, 0);
    ex(c + 10, S_HALT,  1, 0, 0, 1, 0);
    ex(c + 20, S_PAUSE, 0, 0, 0, 0, 0);
    press_key(0, 8);
    press_key(2, 8);
    c = cyc;
    ex(c + 6, S_PAUSE, 0, 1, 0, 0, 0);
    press_key(3, 8);

    // 2-cycle glitch rejected, 5-cycle pulse accepted once.
    c = cyc;
    ex(c + 14, S_PAUSE, 0, 1, 0, 0, 0);
    key_n[3] = 1'b0;
    wait_cyc(2);
    key_n[3] = 1'b1;
    wait_cyc(6);
    key_n[3] = 1'b0;
    wait_cyc(5);
    key_n[3] = 1'b1;
    wait_cyc(6);

    // Down at zero: wraps with stop_mode=0, blocked with stop_mode=1.
    stop_mode = 1'b0;
    cnt_q = 3'd0;
    c = cyc;
    ex(c + 6, S_PAUSE, 0, 1, 0, 0, 0);
    press_key(3, 8);
    stop_mode = 1'b1;
    press_key(3, 8);

    // Reset mid-RUN while counting down.
    stop_mode = 1'b0;
    cnt_q = 3'd3;
    c = cyc;
    ex(c + 6,  S_RUN, 0, 0, 0, 0, 0);
    ex(c + 10, S_RUN, 0, 1, 0, 1, 0);
    key_n[0] = 1'b0;
    wait_cyc(8);
    key_n[0] = 1'b1;
    wait_cyc(4);
    reset = 1'b1;
    #1;
    check("midrst_state", 32'(state_o), 32'(S_IDLE));
    check("midrst_up", 32'(cnt_up), 1);
    check("midrst_en", 32'(cnt_en), 0);
    check("midrst_load", 32'(cnt_load), 0);
    check("midrst_tick", 32'(tick_o), 0);
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(20);

    check("pending_events", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
